sqrt_iter_core: RTL and testbench

Iterative radix-2 restoring integer square-root engine with a start/done handshake, used as the significand-root stage of the single-precision sqrt datapath in the FP divide/sqrt unit. The initiator presents a 2W-bit unsigned radicand and raises `start`. The core produces floor(sqrt), the remainder and an inexact (sticky) bit, then pulses `done` once per accepted operation. It is the responder side of the same `start`/`done` protocol used by the iterative divide path.

---
 rtl/sqrt_iter_if.sv | 23 ++
 rtl/sqrt_iter_core.sv | 103 ++++++++++
 tb/tb_sqrt_iter_core.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sqrt_iter_if.sv
// start/done handshake bundle for the iterative square-root engine.
// master = initiator (drives start/radicand), slave = the sqrt core.
interface sqrt_iter_if #(
    parameter int W = 24
);
    logic             start;
    logic [2*W-1:0]   radicand;
    logic             busy;
    logic             done;
    logic [W-1:0]     root;
    logic [W:0]       rem;
    logic             inexact;

    modport master (
        output start, radicand,
        input  busy, done, root, rem, inexact
    );

    modport slave (
        input  start, radicand,
        output busy, done, root, rem, inexact
    );
endinterface

// File: rtl/sqrt_iter_core.sv
// Radix-2 restoring integer square root: floor(sqrt), remainder and sticky bit.
// Latency W+1 edges from accept to done; one op per rising start, start ignored while busy.
module sqrt_iter_core #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    sqrt_iter_if.slave   bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [2*W-1:0]  rad_sr;
    logic [W+1:0]    p_reg;
    logic [W-1:0]    q_reg;
    logic [CW-1:0]   cnt;

    logic [W+1:0]    p_sh;
    logic [W+1:0]    t_val;
    logic            ge;
    logic [W+1:0]    p_nxt;
    logic [W-1:0]    q_nxt;
    logic            accept;
    logic            last;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_BUSY;
                    accept    = 1'b1;
                end
            end
            S_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                    last      = 1'b1;
                end
            end
            S_DONE: state_nxt = bus.start ? S_HOLD : S_IDLE;
            S_HOLD: if (!bus.start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One restoring step: bring down two radicand bits, trial-subtract 4Q+1.
    always_comb begin
        p_sh  = {p_reg[W-1:0], rad_sr[2*W-1 -: 2]};
        t_val = {q_reg, 2'b01};
        ge    = (p_sh >= t_val);
        p_nxt = ge ? (p_sh - t_val) : p_sh;
        q_nxt = {q_reg[W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rad_sr      <= '0;
            p_reg       <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.root    <= '0;
            bus.rem     <= '0;
            bus.inexact <= 1'b0;
        end else begin
            bus.busy <= (state_nxt == S_BUSY) || (state_nxt == S_DONE);
            bus.done <= (state_nxt == S_DONE);
            if (accept) begin
                rad_sr <= bus.radicand;
                p_reg  <= '0;
                q_reg  <= '0;
                cnt    <= CW'(W - 1);
            end else if (state == S_BUSY) begin
                rad_sr <= rad_sr << 2;
                p_reg  <= p_nxt;
                q_reg  <= q_nxt;
                cnt    <= cnt - CW'(1);
            end
            // Results only move on the final iteration; held otherwise.
            if (last) begin
                bus.root    <= q_nxt;
                bus.rem     <= p_nxt[W:0];
                bus.inexact <= |p_nxt;
            end
        end
    end
endmodule

// File: tb/tb_sqrt_iter_core.sv
// Directed-vector bench for sqrt_iter_core (W=24): result table plus
// held-start, back-to-back and mid-operation reset sequences.
module tb_sqrt_iter_core;
    localparam int W = 24;

    logic clk;
    logic reset;

    sqrt_iter_if #(.W(W)) bus ();

    sqrt_iter_core #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] rad;
        logic [W-1:0]   root;
        logic [W:0]     rem;
        logic           inexact;
    } vec_t;

    vec_t vecs[12];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, drops start after the accept and counts edges
    // (accept edge included) until done is observed.
    task automatic run_op(input logic [2*W-1:0] r, output int lat);
        bus.start    = 1'b1;
        bus.radicand = r;
        tick();
        bus.start    = 1'b0;
        bus.radicand = ~r;
        lat = 1;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{48'd0,                 24'd0,        25'd0,         1'b0};
        vecs[1]  = '{48'd144,               24'd12,       25'd0,         1'b0};
        vecs[2]  = '{48'd2,                 24'd1,        25'd1,         1'b1};
        vecs[3]  = '{48'hFFFF_FFFF_FFFF,    24'hFFFFFF,   25'h1FFFFFE,   1'b1};
        vecs[4]  = '{48'd1,                 24'd1,        25'd0,         1'b0};
        vecs[5]  = '{48'd3,                 24'd1,        25'd2,         1'b1};
        vecs[6]  = '{48'd15,                24'd3,        25'd6,         1'b1};
        vecs[7]  = '{48'd81,                24'd9,        25'd0,         1'b0};
        vecs[8]  = '{48'd1000000,           24'd1000,     25'd0,         1'b0};
        vecs[9]  = '{48'd999999,            24'd999,      25'd1998,      1'b1};
        vecs[10] = '{48'h4000_0000_0000,    24'h800000,   25'd0,         1'b0};
        vecs[11] = '{48'h0000_0100_0000,    24'h001000,   25'd0,         1'b0};

        bus.start    = 1'b0;
        bus.radicand = '0;
        reset        = 1'b0;
        tick();
        tick();
        chk("rst_busy",    {63'd0, bus.busy},    64'd0);
        chk("rst_done",    {63'd0, bus.done},    64'd0);
        chk("rst_root",    {40'd0, bus.root},    64'd0);
        chk("rst_rem",     {39'd0, bus.rem},     64'd0);
        chk("rst_inexact", {63'd0, bus.inexact}, 64'd0);
        reset = 1'b1;
        tick();

        // Table: requests issued back to back at the minimum W+2 period.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].rad, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(W + 1));
            chk($sformatf("v%0d_root", i),    {40'd0, bus.root},    {40'd0, vecs[i].root});
            chk($sformatf("v%0d_rem", i),     {39'd0, bus.rem},     {39'd0, vecs[i].rem});
            chk($sformatf("v%0d_inexact", i), {63'd0, bus.inexact}, {63'd0, vecs[i].inexact});
            chk($sformatf("v%0d_busy", i),    {63'd0, bus.busy},    64'd1);
            tick();
            chk($sformatf("v%0d_pulse", i),   {63'd0, bus.done},    64'd0);
            chk($sformatf("v%0d_hold", i),    {40'd0, bus.root},    {40'd0, vecs[i].root});
        end

        // start held for 60 cycles: exactly one operation, no resample.
        bus.start    = 1'b1;
        bus.radicand = 48'h4000_0000_0000;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (c == 3) bus.radicand = 48'h0000_0000_0009;
            if (bus.done) pulses++;
        end
        chk("held_pulses", 64'(pulses), 64'd1);
        chk("held_root",   {40'd0, bus.root}, 64'h800000);
        chk("held_rem",    {39'd0, bus.rem},  64'd0);
        chk("held_busy",   {63'd0, bus.busy}, 64'd0);
        bus.start = 1'b0;
        tick();
        run_op(48'd1, lat);
        chk("after_held_latency", 64'(lat), 64'(W + 1));
        chk("after_held_root",    {40'd0, bus.root}, 64'd1);
        chk("after_held_rem",     {39'd0, bus.rem},  64'd0);
        tick();

        // Abort at iteration 10: everything clears, no done ever appears.
        bus.start    = 1'b1;
        bus.radicand = 48'hFFFF_FFFF_FFFF;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        tick();
        chk("abort_busy",    {63'd0, bus.busy},    64'd0);
        chk("abort_done",    {63'd0, bus.done},    64'd0);
        chk("abort_root",    {40'd0, bus.root},    64'd0);
        chk("abort_rem",     {39'd0, bus.rem},     64'd0);
        chk("abort_inexact", {63'd0, bus.inexact}, 64'd0);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);

        // start already high at release is accepted on the first edge.
        bus.start    = 1'b1;
        bus.radicand = 48'd81;
        tick();
        chk("inreset_busy", {63'd0, bus.busy}, 64'd0);
        reset = 1'b1;
        tick();
        chk("release_accept_busy", {63'd0, bus.busy}, 64'd1);
        bus.start    = 1'b0;
        bus.radicand = 48'd0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
        chk("post_reset_latency", 64'(lat), 64'(W + 1));
        chk("post_reset_root",    {40'd0, bus.root},    64'd9);
        chk("post_reset_inexact", {63'd0, bus.inexact}, 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
